// File: rtl/serial_link_cfg_regs.sv
// serial_link_cfg_regs: configuration register block for a serial link.
//   Register map (full 32-bit decode, anything else errors):
//     0x000 Status       : [0] link_up_i (RO), [1] train_done sticky (W1C),
//                          [2] train_start (WO, reads 0), [31] lock
//     0x008 TrainingMask : [NumLanes-1:0] RW -> training_mask_o
//     0x010 Delay        : [DelayWidth-1:0] RW -> delay_o (+ delay_update_o pulse)
//   Ports:
//     clk_i, rst_i                  clock, async active-high reset
//     req_valid_i/req_ready_o       request handshake (one outstanding)
//     req_write_i/addr/wdata/wstrb  request payload, byte strobes
//     rsp_valid_o/rsp_ready_i       response handshake, latency 1
//     rsp_rdata_o/rsp_error_o       response payload
//     link_up_i, train_done_i       link status inputs
//     training_mask_o, delay_o, delay_update_o, train_start_o  link controls
//   Build option: SERIAL_LINK_CFG_LOCK_EN adds the Status[31] lock, which
//   makes TrainingMask/Delay writes error until reset.
module serial_link_cfg_regs #(
  parameter int unsigned NumLanes   = 8,
  parameter int unsigned DelayWidth = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0]            req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_error_o,
  input  logic                  link_up_i,
  input  logic                  train_done_i,
  output logic [NumLanes-1:0]   training_mask_o,
  output logic [DelayWidth-1:0] delay_o,
  output logic                  delay_update_o,
  output logic                  train_start_o
);

  localparam logic [31:0] AddrStatus = 32'h0000_0000;
  localparam logic [31:0] AddrMask   = 32'h0000_0008;
  localparam logic [31:0] AddrDelay  = 32'h0000_0010;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [NumLanes-1:0]   mask_q, mask_d;
  logic [DelayWidth-1:0] delay_q, delay_d;
  logic                  delay_update_q, delay_update_d;
  logic                  train_start_q, train_start_d;
  logic                  done_q, done_d;
  logic                  train_done_prev_q, train_done_prev_d;

  logic        accept;
  logic        hit_status, hit_mask, hit_delay;
  logic        done_rise;
  logic        lock_bit;
  logic [31:0] byte_mask;
  logic [31:0] status_rdata;
  logic        unused_ok;

`ifdef SERIAL_LINK_CFG_LOCK_EN
  logic lock_q, lock_d;
  assign lock_bit = lock_q;
`else
  assign lock_bit = 1'b0;
`endif

  assign accept       = req_valid_i && !rsp_valid_q;
  assign hit_status   = (req_addr_i == AddrStatus);
  assign hit_mask     = (req_addr_i == AddrMask);
  assign hit_delay    = (req_addr_i == AddrDelay);
  assign done_rise    = train_done_i && !train_done_prev_q;
  assign byte_mask    = {{8{req_wstrb_i[3]}}, {8{req_wstrb_i[2]}},
                         {8{req_wstrb_i[1]}}, {8{req_wstrb_i[0]}}};
  assign status_rdata = {lock_bit, 28'b0, 1'b0, done_q, link_up_i};
  assign unused_ok    = ^{req_wdata_i, byte_mask};

  always_comb begin
    rsp_valid_d       = rsp_valid_q;
    rsp_rdata_d       = rsp_rdata_q;
    rsp_error_d       = rsp_error_q;
    mask_d            = mask_q;
    delay_d           = delay_q;
    delay_update_d    = 1'b0;
    train_start_d     = 1'b0;
    done_d            = done_q;
    train_done_prev_d = train_done_i;
`ifdef SERIAL_LINK_CFG_LOCK_EN
    lock_d            = lock_q;
`endif

    if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_error_d = 1'b0;
    end

    // accept and response handshake are mutually exclusive (ready = !rsp_valid)
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_error_d = 1'b0;
      if (!(hit_status || hit_mask || hit_delay)) begin
        rsp_error_d = 1'b1;
      end else if (!req_write_i) begin
        if (hit_status)    rsp_rdata_d = status_rdata;
        else if (hit_mask) rsp_rdata_d = 32'(mask_q);
        else               rsp_rdata_d = 32'(delay_q);
      end else if (hit_status) begin
        if (req_wstrb_i[0] && req_wdata_i[1]) done_d        = 1'b0;
        if (req_wstrb_i[0] && req_wdata_i[2]) train_start_d = 1'b1;
`ifdef SERIAL_LINK_CFG_LOCK_EN
        if (req_wstrb_i[3] && req_wdata_i[31]) lock_d = 1'b1;
`endif
      end else if (lock_bit) begin
        rsp_error_d = 1'b1;
      end else if (hit_mask) begin
        mask_d = (mask_q & ~byte_mask[NumLanes-1:0])
               | (req_wdata_i[NumLanes-1:0] & byte_mask[NumLanes-1:0]);
      end else if (|byte_mask[DelayWidth-1:0]) begin
        delay_d        = (delay_q & ~byte_mask[DelayWidth-1:0])
                       | (req_wdata_i[DelayWidth-1:0] & byte_mask[DelayWidth-1:0]);
        delay_update_d = 1'b1;
      end
    end

    // a new training-done edge overrides a same-cycle W1C
    if (done_rise) done_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q       <= 1'b0;
      rsp_rdata_q       <= '0;
      rsp_error_q       <= 1'b0;
      mask_q            <= '1;
      delay_q           <= '0;
      delay_update_q    <= 1'b0;
      train_start_q     <= 1'b0;
      done_q            <= 1'b0;
      train_done_prev_q <= 1'b0;
`ifdef SERIAL_LINK_CFG_LOCK_EN
      lock_q            <= 1'b0;
`endif
    end else begin
      rsp_valid_q       <= rsp_valid_d;
      rsp_rdata_q       <= rsp_rdata_d;
      rsp_error_q       <= rsp_error_d;
      mask_q            <= mask_d;
      delay_q           <= delay_d;
      delay_update_q    <= delay_update_d;
      train_start_q     <= train_start_d;
      done_q            <= done_d;
      train_done_prev_q <= train_done_prev_d;
`ifdef SERIAL_LINK_CFG_LOCK_EN
      lock_q            <= lock_d;
`endif
    end
  end

  assign req_ready_o     = !rsp_valid_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_error_o     = rsp_error_q;
  assign training_mask_o = mask_q;
  assign delay_o         = delay_q;
  assign delay_update_o  = delay_update_q;
  assign train_start_o   = train_start_q;

endmodule

// File: tb/tb_serial_link_cfg_regs.sv
module tb_serial_link_cfg_regs;
  localparam int unsigned NumLanes   = 8;
  localparam int unsigned DelayWidth = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid_i, req_ready_o, req_write_i;
  logic [31:0]           req_addr_i, req_wdata_i;
  logic [3:0]            req_wstrb_i;
  logic                  rsp_valid_o, rsp_ready_i;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_error_o;
  logic                  link_up_i, train_done_i;
  logic [NumLanes-1:0]   training_mask_o;
  logic [DelayWidth-1:0] delay_o;
  logic                  delay_update_o, train_start_o;

  always #5 clk = ~clk;

  serial_link_cfg_regs #(.NumLanes(NumLanes), .DelayWidth(DelayWidth)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .link_up_i(link_up_i), .train_done_i(train_done_i),
    .training_mask_o(training_mask_o), .delay_o(delay_o),
    .delay_update_o(delay_update_o), .train_start_o(train_start_o)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Response scoreboard: pop one expectation per completed handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid_o && rsp_ready_i) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response", rsp_rdata_o, rsp_error_o);
      end else begin
        e = sb_q.pop_front();
        if (rsp_rdata_o !== e.rdata || rsp_error_o !== e.err) begin
          tests_failed++;
          $display("FAIL %s: got rdata=%h err=%b, required rdata=%h err=%b",
                   e.name, rsp_rdata_o, rsp_error_o, e.rdata, e.err);
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rdata,
                        input logic exp_err, input string name);
    int unsigned n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_ready_timeout: got req_ready=0, required 1", name);
      return;
    end
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_wstrb_i = strb;
    sb_q.push_back('{exp_rdata, exp_err, name});
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL rsp_timeout: got %0d responses outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({rsp_valid_o, rsp_rdata_o, rsp_error_o, delay_update_o, train_start_o} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_rsp: got valid=%b rdata=%h err=%b upd=%b start=%b, required all 0",
               rsp_valid_o, rsp_rdata_o, rsp_error_o, delay_update_o, train_start_o);
    end
    tests_run++;
    if (training_mask_o !== 8'hFF || delay_o !== 5'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: got mask=%h delay=%h, required mask=ff delay=00", training_mask_o, delay_o);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests_run++;
    if (req_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b, required 1", req_ready_o);
    end
    do_req(1'b0, 32'h008, 32'h0, 4'h0, 32'h0000_00FF, 1'b0, "rd_mask_reset");
    do_req(1'b0, 32'h010, 32'h0, 4'h0, 32'h0, 1'b0, "rd_delay_reset");
    wait_idle();
  endtask

  task automatic test_delay();
    do_req(1'b1, 32'h010, 32'h13, 4'h1, 32'h0, 1'b0, "wr_delay_13");
    tests_run++;
    if (delay_o !== 5'h13 || delay_update_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL delay_update: got delay=%h upd=%b, required delay=13 upd=1", delay_o, delay_update_o);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (delay_update_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL delay_pulse_len: got upd=%b, required 0", delay_update_o);
    end
    do_req(1'b1, 32'h010, 32'hFF, 4'h0, 32'h0, 1'b0, "wr_delay_nostrb");
    tests_run++;
    if (delay_o !== 5'h13 || delay_update_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL delay_nostrb: got delay=%h upd=%b, required delay=13 upd=0", delay_o, delay_update_o);
    end
    do_req(1'b1, 32'h010, 32'h13, 4'h1, 32'h0, 1'b0, "wr_delay_same");
    tests_run++;
    if (delay_update_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL delay_same_value: got upd=%b, required 1", delay_update_o);
    end
    do_req(1'b0, 32'h010, 32'h0, 4'h0, 32'h13, 1'b0, "rd_delay_13");
    do_req(1'b1, 32'h010, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, "wr_delay_all");
    do_req(1'b0, 32'h010, 32'h0, 4'h0, 32'h1F, 1'b0, "rd_delay_1f");
    wait_idle();
  endtask

  task automatic test_mask();
    do_req(1'b1, 32'h008, 32'hA5, 4'h1, 32'h0, 1'b0, "wr_mask_a5");
    do_req(1'b1, 32'h008, 32'h0, 4'hE, 32'h0, 1'b0, "wr_mask_upper");
    do_req(1'b0, 32'h008, 32'h0, 4'h0, 32'hA5, 1'b0, "rd_mask_a5");
    wait_idle();
    tests_run++;
    if (training_mask_o !== 8'hA5) begin
      tests_failed++;
      $display("FAIL mask_out: got %h, required a5", training_mask_o);
    end
    do_req(1'b1, 32'h008, 32'hFF, 4'h1, 32'h0, 1'b0, "wr_mask_ff");
    wait_idle();
  endtask

  task automatic test_unmapped();
    do_req(1'b0, 32'h004, 32'h0, 4'h0, 32'h0, 1'b1, "rd_004");
    do_req(1'b0, 32'h00C, 32'h0, 4'h0, 32'h0, 1'b1, "rd_00c");
    do_req(1'b1, 32'h009, 32'h0, 4'hF, 32'h0, 1'b1, "wr_009");
    do_req(1'b1, 32'h1000_0010, 32'h0, 4'hF, 32'h0, 1'b1, "wr_alias_delay");
    do_req(1'b0, 32'h018, 32'h0, 4'h0, 32'h0, 1'b1, "rd_018");
    wait_idle();
    tests_run++;
    if (training_mask_o !== 8'hFF || delay_o !== 5'h1F) begin
      tests_failed++;
      $display("FAIL unmapped_nochange: got mask=%h delay=%h, required ff/1f", training_mask_o, delay_o);
    end
  endtask

  task automatic test_status();
    link_up_i = 1'b1;
    @(negedge clk) train_done_i = 1'b1;
    @(negedge clk) train_done_i = 1'b0;
    do_req(1'b0, 32'h000, 32'h0, 4'h0, 32'h3, 1'b0, "rd_status_3");
    do_req(1'b1, 32'h000, 32'h2, 4'h1, 32'h0, 1'b0, "w1c_done");
    do_req(1'b0, 32'h000, 32'h0, 4'h0, 32'h1, 1'b0, "rd_status_1");
    wait_idle();
    // W1C accepted on the same edge that sees train_done_i rise
    @(negedge clk);
    train_done_i = 1'b1;
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h000;
    req_wdata_i = 32'h2;
    req_wstrb_i = 4'h1;
    sb_q.push_back('{32'h0, 1'b0, "w1c_vs_set"});
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    do_req(1'b0, 32'h000, 32'h0, 4'h0, 32'h3, 1'b0, "rd_set_wins");
    link_up_i = 1'b0;
    do_req(1'b1, 32'h000, 32'h2, 4'h1, 32'h0, 1'b0, "w1c_level_high");
    do_req(1'b0, 32'h000, 32'h0, 4'h0, 32'h0, 1'b0, "rd_status_0");
    wait_idle();
    train_done_i = 1'b0;
    link_up_i = 1'b1;
  endtask

  task automatic test_backpressure();
    rsp_ready_i = 1'b0;
    do_req(1'b0, 32'h010, 32'h0, 4'h0, 32'h1F, 1'b0, "rd_stalled");
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h008;
    req_wdata_i = 32'h0;
    req_wstrb_i = 4'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h1F || rsp_error_o !== 1'b0 || req_ready_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d: got valid=%b rdata=%h err=%b ready=%b, required 1/0000001f/0/0",
                 i, rsp_valid_o, rsp_rdata_o, rsp_error_o, req_ready_o);
      end
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    wait_idle();
    tests_run++;
    if (training_mask_o !== 8'hFF) begin
      tests_failed++;
      $display("FAIL stall_no_accept: got mask=%h, required ff", training_mask_o);
    end
  endtask

  task automatic test_train_start();
    int pulses = 0;
    do_req(1'b1, 32'h000, 32'h4, 4'h1, 32'h0, 1'b0, "wr_train_start");
    tests_run++;
    if (train_start_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL train_start_pulse: got %b, required 1", train_start_o);
    end
    do_req(1'b1, 32'h000, 32'h4, 4'h0, 32'h0, 1'b0, "wr_start_nostrb");
    for (int i = 0; i < 4; i++) begin
      pulses += int'(train_start_o);
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL train_start_extra: got %0d extra pulse cycles, required 0", pulses);
    end
    do_req(1'b0, 32'h000, 32'h0, 4'h0, 32'h1, 1'b0, "rd_start_reads0");
    wait_idle();
  endtask

  task automatic test_lock();
`ifdef SERIAL_LINK_CFG_LOCK_EN
    do_req(1'b1, 32'h000, 32'h8000_0000, 4'h8, 32'h0, 1'b0, "wr_lock");
    do_req(1'b0, 32'h000, 32'h0, 4'h0, 32'h8000_0001, 1'b0, "rd_locked");
    do_req(1'b1, 32'h008, 32'h0F, 4'h1, 32'h0, 1'b1, "wr_mask_locked");
    do_req(1'b1, 32'h010, 32'h03, 4'h1, 32'h0, 1'b1, "wr_delay_locked");
    tests_run++;
    if (delay_update_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL locked_update: got %b, required 0", delay_update_o);
    end
    wait_idle();
    tests_run++;
    if (training_mask_o !== 8'hFF || delay_o !== 5'h1F) begin
      tests_failed++;
      $display("FAIL locked_nochange: got mask=%h delay=%h, required ff/1f", training_mask_o, delay_o);
    end
    apply_reset();
`else
    do_req(1'b1, 32'h000, 32'h8000_0000, 4'h8, 32'h0, 1'b0, "wr_bit31");
    do_req(1'b0, 32'h000, 32'h0, 4'h0, 32'h1, 1'b0, "rd_bit31_zero");
`endif
    do_req(1'b1, 32'h008, 32'h0F, 4'h1, 32'h0, 1'b0, "wr_mask_unlocked");
    wait_idle();
    tests_run++;
    if (training_mask_o !== 8'h0F) begin
      tests_failed++;
      $display("FAIL unlocked_mask: got %h, required 0f", training_mask_o);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready_i = 1'b0;
    do_req(1'b0, 32'h010, 32'h0, 4'h0, 32'h0, 1'b0, "rd_dropped");
    rst = 1'b1;
    sb_q.delete();
    #1;
    tests_run++;
    if (rsp_valid_o !== 1'b0 || training_mask_o !== 8'hFF) begin
      tests_failed++;
      $display("FAIL reset_mid: got valid=%b mask=%h, required 0/ff", rsp_valid_o, training_mask_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_idle: got ready=%b valid=%b, required 1/0", req_ready_o, rsp_valid_o);
    end
    do_req(1'b0, 32'h008, 32'h0, 4'h0, 32'hFF, 1'b0, "rd_after_reset_mid");
    wait_idle();
  endtask

  initial begin
    req_valid_i  = 1'b0;
    req_write_i  = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    req_wstrb_i  = '0;
    rsp_ready_i  = 1'b1;
    link_up_i    = 1'b0;
    train_done_i = 1'b0;
    rst          = 1'b1;
    test_reset();
    test_delay();
    test_mask();
    test_unmapped();
    test_status();
    test_backpressure();
    test_train_start();
    test_lock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/serial_link_cfg_regs.md
SERIAL_LINK_CFG_REGS -- requirements
Module: serial_link_cfg_regs

Interface
REQ-001 SHALL have parameter NumLanes, default 8, giving training mask width (1..32).
REQ-002 SHALL have parameter DelayWidth, default 5, giving lane delay tap width (1..16).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_valid_i input 1 / req_ready_o output 1  request handshake.
REQ-006 SHALL have ports req_write_i input 1, req_addr_i input 32, req_wdata_i input 32, req_wstrb_i input 4  request payload (byte strobes).
REQ-007 SHALL have ports rsp_valid_o output 1 / rsp_ready_i input 1  response handshake.
REQ-008 SHALL have ports rsp_rdata_o output 32, rsp_error_o output 1  response payload.
REQ-009 SHALL have ports link_up_i input 1 (live link state), train_done_i input 1 (training-complete level from link).
REQ-010 SHALL have ports training_mask_o output NumLanes, delay_o output DelayWidth, delay_update_o output 1, train_start_o output 1.

Function
REQ-011 SHALL decode full 32-bit address: 0x000 Status, 0x008 TrainingMask, 0x010 Delay; any other address or addr[1:0]!=0 is unmapped.
REQ-012 SHALL accept a request on cycle where req_valid_i && req_ready_o; req_ready_o = !rsp_valid_o (one outstanding transaction).
REQ-013 SHALL raise rsp_valid_o the cycle after acceptance (latency 1) and hold rsp_valid_o, rsp_rdata_o, rsp_error_o stable until rsp_ready_i is high.
REQ-014 SHALL respond to unmapped access with rsp_error_o=1, rsp_rdata_o=0, no state change.
REQ-015 SHALL apply writes per byte strobe; bytes with strobe 0 unchanged; write response rdata=0.
REQ-016 Status layout: bit0 link_up_i (RO, sampled at acceptance), bit1 train_done sticky (W1C), bit2 train_start (WO, reads 0), other bits read 0 (bit31 see REQ-026).
REQ-017 SHALL set train_done sticky on rising edge of train_done_i (registered edge detect); set SHALL win over same-cycle W1C.
REQ-018 SHALL pulse train_start_o high exactly one cycle, the cycle after a Status write with wdata[2]=1 and wstrb[0]=1.
REQ-019 TrainingMask: bits [NumLanes-1:0] RW, drive training_mask_o directly; upper bits read 0, writes ignored.
REQ-020 Delay: bits [DelayWidth-1:0] RW, drive delay_o directly; upper bits read 0.
REQ-021 SHALL pulse delay_update_o one cycle, coincident with delay_o taking new value, on every accepted Delay write with any relevant strobe set (even if value unchanged).
REQ-022 Reads SHALL return register value as of acceptance cycle.
REQ-023 A transaction accepted while rsp_ready_i is high in same cycle as prior response SHALL NOT occur (ready low while response pending).

Reset
REQ-024 On rst_i high, asynchronously: rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, req_ready_o=1 after deassertion, training_mask_o=all ones, delay_o=0, delay_update_o=0, train_start_o=0, train_done sticky=0.
REQ-025 Reset mid-transaction SHALL drop pending response; no response SHALL be issued for it.

Configuration
REQ-026 With SERIAL_LINK_CFG_LOCK_EN defined: Status bit31 = lock, write 1 sets it, only reset clears it; writes to TrainingMask/Delay while locked return rsp_error_o=1 with no update and no delay_update_o pulse; Status writes still allowed.
REQ-027 Without SERIAL_LINK_CFG_LOCK_EN: bit31 reads 0, writes to it ignored, no lock-related error, no lock flop.

Verification
REQ-028 Reset, read 0x008 -> rsp rdata=0x000000FF, error=0; read 0x010 -> rdata=0x0.
REQ-029 Write 0x010 data 0x13 strb 0x1 -> delay_o=0x13 with one-cycle delay_update_o; read back 0x13.
REQ-030 Read 0x004 and 0x00C -> rsp_error_o=1, rdata=0, registers unchanged.
REQ-031 Pulse train_done_i, read 0x000 with link_up_i=1 -> rdata=0x3; write 0x2 -> next read 0x1; W1C coincident with edge -> bit1 stays 1.
REQ-032 Hold rsp_ready_i=0 for 5 cycles after request -> rsp stable, req_ready_o=0 throughout; write 0x4 to 0x000 -> single train_start_o pulse.
REQ-033 With SERIAL_LINK_CFG_LOCK_EN: write 0x80000000 to 0x000, then write 0x0F to 0x008 -> error=1, training_mask_o stays 0xFF; reset clears lock.
